// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings and widths for the pipeline stages.
package pipeline_pkg;

  localparam int DATA_W      = 32;
  localparam int BE_W        = DATA_W / 8;
  localparam int REG_ADDR_W  = 5;
  localparam int INSTR_IDX_W = 26;

  typedef enum logic [1:0] {
    LS_WORD     = 2'b00,
    LS_HALF     = 2'b01,
    LS_BYTE     = 2'b10,
    LS_WORD_ALT = 2'b11
  } ls_size_e;

  typedef enum logic [1:0] {
    BR_NONE     = 2'b00,
    BR_EQ       = 2'b01,
    BR_NE       = 2'b10,
    BR_NONE_ALT = 2'b11
  } branch_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// mem_align: store byte-lane/byte-enable formatting and load lane extraction with sign/zero extension.
module mem_align
  import pipeline_pkg::*;
(
  input  ls_size_e          size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic              ext_op_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
    case (size_i)
      LS_HALF: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = {{16{ext_op_i & half_sel[15]}}, half_sel};
      end
      LS_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{ext_op_i & byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage -- data-memory port, branch/jump redirect, busy stall, MEM/WB register.
// Build option MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int          ADDR_W        = 32,
  parameter logic [31:0] RESET_PC_LINK = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             EX_MEM_LS_bit,
  input  logic [1:0]             EX_MEM_Branch,
  input  logic                   EX_MEM_MemtoReg,
  input  logic                   EX_MEM_MemWrite,
  input  logic                   EX_MEM_RegWrite,
  input  logic                   EX_MEM_Jump,
  input  logic                   EX_MEM_Ext_op,
  input  logic                   EX_MEM_PctoReg,
  input  logic                   EX_MEM_zero,
  input  logic [DATA_W-1:0]      EX_MEM_branch_add_out,
  input  logic [DATA_W-1:0]      EX_MEM_pc_add_out,
  input  logic [DATA_W-1:0]      EX_MEM_alu_out,
  input  logic [DATA_W-1:0]      EX_MEM_regfile_out2,
  input  logic [INSTR_IDX_W-1:0] EX_MEM_instr26,
  input  logic [REG_ADDR_W-1:0]  EX_MEM_mux1_out,
  output logic                   dm_req,
  output logic                   dm_we,
  output logic [ADDR_W-1:0]      dm_addr,
  output logic [BE_W-1:0]        dm_be,
  output logic [DATA_W-1:0]      dm_wdata,
  input  logic [DATA_W-1:0]      dm_rdata,
  input  logic                   dm_ready,
  output logic                   pc_redirect,
  output logic [DATA_W-1:0]      pc_target,
  output logic                   mem_stall,
  output logic                   MEM_WB_RegWrite,
  output logic                   MEM_WB_MemtoReg,
  output logic                   MEM_WB_PctoReg,
  output logic [DATA_W-1:0]      MEM_WB_load_data,
  output logic [DATA_W-1:0]      MEM_WB_alu_out,
  output logic [DATA_W-1:0]      MEM_WB_pc_add_out,
  output logic [REG_ADDR_W-1:0]  MEM_WB_mux1_out
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_err
`endif
);

  ls_size_e          ls_size;
  branch_e           br_kind;
  mem_state_e        state_q, state_d;
  logic              mem_op, trap, branch_taken;
  logic [1:0]        align_mask;
  logic [DATA_W-1:0] eff_addr, load_data;

  assign ls_size = ls_size_e'(EX_MEM_LS_bit);
  assign br_kind = branch_e'(EX_MEM_Branch);
  assign mem_op  = EX_MEM_MemWrite | EX_MEM_MemtoReg;

  // Low address bits that must be zero for the access size.
  always_comb begin
    case (ls_size)
      LS_HALF: align_mask = 2'b01;
      LS_BYTE: align_mask = 2'b00;
      default: align_mask = 2'b11;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap     = mem_op & (|(EX_MEM_alu_out[1:0] & align_mask));
  assign eff_addr = EX_MEM_alu_out;
`else
  assign trap     = 1'b0;
  assign eff_addr = {EX_MEM_alu_out[DATA_W-1:2], EX_MEM_alu_out[1:0] & ~align_mask};
`endif

  assign dm_req  = mem_op & ~trap;
  assign dm_we   = EX_MEM_MemWrite;
  assign dm_addr = eff_addr[ADDR_W-1:0];

  mem_align u_align (
    .size_i      (ls_size),
    .addr_lo_i   (eff_addr[1:0]),
    .ext_op_i    (EX_MEM_Ext_op),
    .store_data_i(EX_MEM_regfile_out2),
    .rdata_i     (dm_rdata),
    .be_o        (dm_be),
    .wdata_o     (dm_wdata),
    .load_data_o (load_data)
  );

  assign branch_taken = ((br_kind == BR_EQ) &&  EX_MEM_zero) ||
                        ((br_kind == BR_NE) && !EX_MEM_zero);
  assign pc_redirect  = EX_MEM_Jump | branch_taken;
  assign pc_target    = EX_MEM_Jump ? {EX_MEM_pc_add_out[31:28], EX_MEM_instr26, 2'b00}
                                    : EX_MEM_branch_add_out;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_stall = dm_req & ~dm_ready;
    case (state_q)
      ST_IDLE: if (mem_stall)            state_d = ST_WAIT;
      ST_WAIT: if (dm_ready || !dm_req)  state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  logic                  wb_reg_write_q, wb_mem_to_reg_q, wb_pc_to_reg_q;
  logic [DATA_W-1:0]     wb_load_data_q, wb_alu_out_q, wb_pc_add_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  always_ff @(posedge clock) begin
    // NOTE: data fields are reset as well; the link register must come up holding RESET_PC_LINK.
    if (reset) begin
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_pc_to_reg_q  <= 1'b0;
      wb_load_data_q  <= '0;
      wb_alu_out_q    <= '0;
      wb_pc_add_q     <= RESET_PC_LINK;
      wb_rd_q         <= '0;
    end else if (mem_stall || trap) begin
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_pc_to_reg_q  <= 1'b0;
    end else begin
      wb_reg_write_q  <= EX_MEM_RegWrite;
      wb_mem_to_reg_q <= EX_MEM_MemtoReg;
      wb_pc_to_reg_q  <= EX_MEM_PctoReg;
      wb_load_data_q  <= load_data;
      wb_alu_out_q    <= EX_MEM_alu_out;
      wb_pc_add_q     <= EX_MEM_pc_add_out;
      wb_rd_q         <= EX_MEM_mux1_out;
    end
  end

  assign MEM_WB_RegWrite   = wb_reg_write_q;
  assign MEM_WB_MemtoReg   = wb_mem_to_reg_q;
  assign MEM_WB_PctoReg    = wb_pc_to_reg_q;
  assign MEM_WB_load_data  = wb_load_data_q;
  assign MEM_WB_alu_out    = wb_alu_out_q;
  assign MEM_WB_pc_add_out = wb_pc_add_q;
  assign MEM_WB_mux1_out   = wb_rd_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= trap;
  end

  assign misalign_err = misalign_q;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the multistage pipeline, between the EX/MEM and MEM/WB boundaries. Consumes the registered EX/MEM bundle, drives the data-memory request/ready port with byte-lane formatting and load extraction, resolves branch/jump redirects, and stalls the front of the pipeline while memory is busy. Owns the MEM/WB pipeline register.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- RESET_PC_LINK, 32'h0000_0000, reset value of MEM_WB_pc_add_out

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- EX_MEM_LS_bit, EX_MEM_Branch  in  2 each  access size / branch kind
- EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_Jump, EX_MEM_Ext_op, EX_MEM_PctoReg, EX_MEM_zero  in  1 each
- EX_MEM_branch_add_out, EX_MEM_pc_add_out, EX_MEM_alu_out, EX_MEM_regfile_out2  in  32 each
- EX_MEM_instr26  in  26;  EX_MEM_mux1_out  in  5
- dm_req, dm_we  out  1;  dm_addr  out  ADDR_W;  dm_be  out  4;  dm_wdata  out  32
- dm_rdata  in  32;  dm_ready  in  1
- pc_redirect  out  1  take pc_target next edge; also flushes IF/ID and ID/EX
- pc_target  out  32
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_PctoReg  out  1 each
- MEM_WB_load_data, MEM_WB_alu_out, MEM_WB_pc_add_out  out  32 each;  MEM_WB_mux1_out  out  5
- misalign_err  out  1  (only with MEM_MISALIGN_TRAP_EN)

## Operation
- Encodings: LS_bit 00 word, 01 half, 10 byte, 11 treated as word. Branch 00 none, 01 beq (taken if zero), 10 bne (taken if !zero), 11 none.
- mem_op = MemWrite | MemtoReg. dm_req = mem_op (suppressed on trapped misalign); dm_we = MemWrite; dm_addr = alu_out.
- Store: word be 1111, wdata = rt; half be = addr[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}; byte be = 1 << addr[1:0], wdata = {4{rt[7:0]}}.
- Load: select lane by addr[1:0]; Ext_op=1 sign-extends, 0 zero-extends; word ignores Ext_op.
- Redirect: Jump -> pc_target = {pc_add_out[31:28], instr26, 2'b00}; else taken branch -> branch_add_out. Jump has priority. Combinational on EX/MEM inputs.
- FSM IDLE/WAIT: IDLE, mem_op & !dm_ready -> WAIT; WAIT, dm_ready -> IDLE. mem_stall = mem_op & !dm_ready in either state. dm_req, dm_addr, dm_be, dm_wdata stay stable while stalled (inputs held upstream).
- MEM/WB register: if mem_stall, loads a bubble (RegWrite, MemtoReg, PctoReg = 0, data don't-care but held); else captures controls, alu_out, pc_add_out, mux1_out, extracted load data.

## Timing
- Reset: FSM IDLE; all MEM_WB controls 0; MEM_WB data 0; MEM_WB_pc_add_out = RESET_PC_LINK; misalign_err 0. Combinational outputs follow inputs.
- Zero-wait memory (dm_ready high with dm_req): no stall, result in MEM/WB next edge (latency 1).
- N-cycle memory: mem_stall high N cycles, MEM/WB bubbles N cycles, real result on the edge where dm_ready is sampled.
- Back-to-back mem ops: no dead cycle between them.
- Branch/jump are never mem ops; redirect is never concurrent with stall.
- Reset mid-WAIT: returns to IDLE next edge; dm_req follows inputs.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 drops dm_req, writes bubble, pulses misalign_err one cycle.
- Undefined: low address bits forced aligned (half clears bit 0, word clears [1:0]); misalign_err absent.

## Structure
- pipeline_pkg: LS_bit and Branch encodings, FSM state enum, width constants.
- Sub-module mem_align: combinational store lane/byte-enable formatting and load extraction/extension.

## Test plan
- Reset -> all MEM_WB controls 0, MEM_WB_pc_add_out = RESET_PC_LINK, mem_stall 0.
- sb rt=0x1234_56AB at addr 0x102, ready=1 -> dm_be 0100, dm_wdata 0xABABABAB, no stall.
- lh addr 0x102, rdata 0x8001_0000, Ext_op=1 -> MEM_WB_load_data 0xFFFF_8001; Ext_op=0 -> 0x0000_8001.
- lw with ready low 3 cycles -> mem_stall 3 cycles, 3 bubbles, then load data captured; FSM back to IDLE.
- bne zero=0, branch_add_out 0x3010 -> pc_redirect 1, pc_target 0x3010; Jump with instr26=0x0000C04, pc_add_out 0x3008 -> pc_target 0x0000_3010.
- Trap build: lw addr 0x101 -> dm_req 0, misalign_err one-cycle pulse, MEM_WB_RegWrite 0.
